// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver: synchronises the serial line, validates the start bit,
// samples each bit at mid-period and strobes the framed byte or a framing error.
module uart_rx_deserializer #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_dat_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       receiving
);

  localparam int unsigned     CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t           state, state_nxt;
  logic             sync_q, line_s;
  logic [CNT_W-1:0] clk_cnt, cnt_nxt;
  logic [2:0]       bit_idx, idx_nxt;
  logic [7:0]       shift_reg, shift_nxt;
  logic [7:0]       data_nxt;
  logic             valid_nxt, ferr_nxt;

  // Both sync stages reset high so a reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 1'b1;
      line_s <= 1'b1;
    end else begin
      sync_q <= serial_dat_in;
      line_s <= sync_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      clk_cnt   <= cnt_nxt;
      bit_idx   <= idx_nxt;
      shift_reg <= shift_nxt;
      rx_data   <= data_nxt;
      rx_valid  <= valid_nxt;
      frame_err <= ferr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = clk_cnt;
    idx_nxt   = bit_idx;
    shift_nxt = shift_reg;
    data_nxt  = rx_data;
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;
    receiving = (state != S_IDLE);

    case (state)
      S_IDLE: begin
        if (!line_s) begin
          state_nxt = S_START;
          cnt_nxt   = '0;
        end
      end
      S_START: begin
        if (clk_cnt == CNT_HALF) begin
          cnt_nxt = '0;
          idx_nxt = '0;
          state_nxt = line_s ? S_IDLE : S_DATA;
        end else begin
          cnt_nxt = clk_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (clk_cnt == CNT_LAST) begin
          shift_nxt[bit_idx] = line_s;
          cnt_nxt = '0;
          if (bit_idx == 3'd7) state_nxt = S_STOP;
          else                 idx_nxt   = bit_idx + 1'b1;
        end else begin
          cnt_nxt = clk_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (clk_cnt == CNT_LAST) begin
          cnt_nxt = '0;
          if (line_s) begin
            data_nxt  = shift_reg;
            valid_nxt = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = S_BREAK;
          end
        end else begin
          cnt_nxt = clk_cnt + 1'b1;
        end
      end
      // A held-low line after a bad stop bit must not be mistaken for a new start.
      S_BREAK: begin
        if (line_s) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
